load_store_unit: RTL and testbench

- Memory-access stage that sits directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and decoded load/store control, and runs one data-memory transaction per instruction over a req/ack handshake.
- Handles RV32I byte/half/word lane steering, store byte enables and load sign/zero extension.
- Holds the pipeline with stall until the access completes.

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/load_store_unit_load_formatter.sv | 24 ++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared symbols for the load/store unit: RV32I funct3 access encodings and FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_formatter.sv
// Combinational load formatter: selects the addressed lane of a read word and extends it.
module load_formatter
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     result = {24'b0, shifted[7:0]};
            LHU:     result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per load/store, stalling upstream.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           address,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  access_fault,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [31:0]           dmem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        accept, illegal, misaligned, bad_access;
    logic [1:0]  size, offset;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, fmt_result;
    logic [2:0]  fmt_funct3_q;
    logic [1:0]  fmt_off_q;
    logic        fault_q;

    always_comb begin
        size = funct3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        offset     = address[1:0];
        misaligned = (size == 2'b01 && address[0]) ||
                     (size == 2'b10 && address[1:0] != 2'b00);
`else
        misaligned = 1'b0;
        case (size)
            2'b00:   offset = address[1:0];
            2'b01:   offset = {address[1], 1'b0};
            default: offset = 2'b00;
        endcase
`endif
        // mem_write wins when both are set, so store legality applies
        illegal = mem_write ? (funct3 > SW)
                            : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        bad_access = illegal || misaligned;

        case (size)
            2'b00:   begin be_d = 4'b0001 << offset; wdata_d = {4{store_data[7:0]}};  end
            2'b01:   begin be_d = 4'b0011 << offset; wdata_d = {2{store_data[15:0]}}; end
            default: begin be_d = 4'b1111;           wdata_d = store_data;            end
        endcase
    end

    // Reset gates accept so stall is low the moment reset is asserted
    assign accept = !reset && state_q == IDLE && valid_in && !flush && (mem_read || mem_write);

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        done         = 1'b0;
        access_fault = 1'b0;
        dmem_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = bad_access ? DONE : REQ;
                end
            end
            REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ack) state_d = DONE;
            end
            DONE: begin
                done         = 1'b1;
                access_fault = fault_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    load_formatter u_fmt (
        .rdata  (dmem_rdata),
        .offset (fmt_off_q),
        .funct3 (fmt_funct3_q),
        .result (fmt_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            load_data    <= '0;
            fmt_funct3_q <= '0;
            fmt_off_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                fault_q <= bad_access;
                if (!bad_access) begin
                    dmem_we      <= mem_write;
                    dmem_addr    <= {address[ADDR_WIDTH-1:2], 2'b00};
                    dmem_be      <= be_d;
                    dmem_wdata   <= wdata_d;
                    fmt_funct3_q <= funct3;
                    fmt_off_q    <= offset;
                end
            end
            if (state_q == REQ && dmem_ack && !dmem_we) load_data <= fmt_result;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, valid_in, flush, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, store_data;
    logic        stall, done, access_fault, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_load = '0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .address(address), .store_data(store_data), .stall(stall), .done(done),
        .load_data(load_data), .access_fault(access_fault), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes and legality from the RV32I rules
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_illegal(input bit st, input logic [2:0] f3);
        if (st) return f3 > 3'd2;
        return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = m_size(f3);
        return ((a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return ((32'd1 << m_size(f3)) - 1) << m_off(f3, a);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned sz = m_size(f3);
        logic [31:0] mask, v;
        if (sz >= 4) return rd;
        mask = (32'd1 << (8 * sz)) - 1;
        v = (rd >> (8 * m_off(f3, a))) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int unsigned dly, input bit flush_req);
        bit st, fault;
        st    = wr;
        fault = m_illegal(st, f3) || m_misaligned(f3, a);
        @(negedge clk);
        valid_in = 1; flush = 0; mem_read = rd; mem_write = wr;
        funct3 = f3; address = a; store_data = sd;
        #1;
        check("accept_stall", stall, 1);
        check("accept_req", dmem_req, 0);
        check("accept_done", done, 0);
        if (!fault) begin
            for (int unsigned c = 0; c <= dly; c++) begin
                @(negedge clk);
                flush      = flush_req;
                dmem_ack   = (c == dly);
                dmem_rdata = (c == dly) ? rdat : $urandom;
                #1;
                check("req_valid", dmem_req, 1);
                check("req_stall", stall, 1);
                check("req_done", done, 0);
                check("req_we", dmem_we, st);
                check("req_addr", dmem_addr, {a[31:2], 2'b00});
                if (st) begin
                    check("req_be", dmem_be, m_be(f3, a));
                    check("req_wdata", dmem_wdata, m_wdata(f3, sd));
                end
            end
            if (!st) exp_load = m_load(f3, a, rdat);
        end
        @(negedge clk);
        dmem_ack = 0; flush = 0; dmem_rdata = $urandom;
        #1;
        check("done_pulse", done, 1);
        check("done_fault", access_fault, fault);
        check("done_stall", stall, 0);
        check("done_req", dmem_req, 0);
        check("done_load", load_data, exp_load);
        @(negedge clk);
        valid_in = 0; mem_read = 0; mem_write = 0;
        #1;
        check("after_done", done, 0);
        check("after_req", dmem_req, 0);
        check("after_stall", stall, 0);
    endtask

    initial begin
        reset = 1; valid_in = 0; flush = 0; mem_read = 0; mem_write = 0;
        funct3 = '0; address = '0; store_data = '0; dmem_ack = 0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_fault", access_fault, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", {28'b0, dmem_be}, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_load", load_data, 0);
        @(negedge clk);
        reset = 0;

        // Directed cases
        run_op(0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_op(0, 1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0, 2, 0);
        run_op(1, 0, 3'b000, 32'h0000_3001, 32'h0, 32'h1234_80FF, 0, 0);
        check("lb_value", exp_load, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h0000_3001, 32'h0, 32'h1234_80FF, 0, 0);
        check("lbu_value", exp_load, 32'h0000_0080);
        run_op(1, 0, 3'b101, 32'h0000_3002, 32'h0, 32'h1234_80FF, 1, 0);
        check("lhu_value", exp_load, 32'h0000_1234);
        run_op(1, 0, 3'b001, 32'h0000_3001, 32'h0, 32'h1234_80FF, 0, 0);
        run_op(0, 1, 3'b100, 32'h0000_3000, 32'h1111_2222, 32'h0, 0, 0);
        run_op(1, 0, 3'b111, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 0, 0);
        run_op(1, 1, 3'b001, 32'h0000_5006, 32'h0000_BEEF, 32'h0, 1, 0);
        run_op(1, 0, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 2, 1);

        // Flushed load in IDLE issues nothing
        @(negedge clk);
        valid_in = 1; flush = 1; mem_read = 1; funct3 = 3'b010; address = 32'h7000;
        #1;
        check("flush_stall", stall, 0);
        @(negedge clk);
        #1;
        check("flush_req", dmem_req, 0);
        check("flush_done", done, 0);
        valid_in = 0; flush = 0; mem_read = 0;

        // Non-memory instruction is transparent; stray ack is ignored
        @(negedge clk);
        valid_in = 1; dmem_ack = 1; dmem_rdata = 32'h9999_9999;
        #1;
        check("nonmem_stall", stall, 0);
        @(negedge clk);
        valid_in = 0; dmem_ack = 0;
        #1;
        check("stray_ack_done", done, 0);
        check("stray_ack_load", load_data, exp_load);

        // Reset in REQ abandons the transaction
        @(negedge clk);
        valid_in = 1; mem_read = 1; funct3 = 3'b010; address = 32'h4000;
        @(negedge clk);
        #1;
        check("prerst_req", dmem_req, 1);
        reset = 1;
        #1;
        exp_load = '0;
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", stall, 0);
        check("midrst_addr", dmem_addr, 0);
        check("midrst_load", load_data, exp_load);
        @(negedge clk);
        reset = 0; valid_in = 0; mem_read = 0;
        #1;
        check("postrst_done", done, 0);
        @(negedge clk);
        #1;
        check("postrst_done2", done, 0);
        check("postrst_req", dmem_req, 0);
        run_op(1, 0, 3'b010, 32'h0000_4004, 32'h0, 32'h0BAD_CAFE, 1, 0);

        // Randomized accesses
        for (int i = 0; i < 120; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            run_op(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
